// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Synchronises and debounces raw push-button / slide-switch pins. Each bit is
// fully independent: a two-flop synchroniser feeds a per-bit stability
// counter, and a new level is only accepted once the synchronised input has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
// Registered one-cycle pulses mark each accepted 0->1 and 1->0 transition.
//
// Parameters:
//   WIDTH            number of independent input bits
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level (>= 1)
//
// Ports:
//   clk_i    system clock, all state changes on the rising edge
//   rst_i    synchronous active-high reset
//   raw_i    asynchronous, bouncing input pins
//   level_o  debounced, registered level per bit
//   rise_o   one-cycle pulse when level_o[i] goes 0->1
//   fall_o   one-cycle pulse when level_o[i] goes 1->0
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [WIDTH-1:0]         level_q, level_d;
    logic [WIDTH-1:0]         rise_q,  rise_d;
    logic [WIDTH-1:0]         fall_q,  fall_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q,   cnt_d;

    // Per-bit two-state machine encoded by the counter: STABLE when the
    // synchronised input matches the level (counter held at 0), PENDING
    // otherwise. Any return to the old level restarts the count from zero,
    // so the counter can never pass CNT_LAST.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = 4'h0;
    logic [3:0] level, rise, fall;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .raw_i   (raw),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always #5 clk = ~clk;

    // rise and fall must never be high together on any bit.
    always @(negedge clk) begin
        checks++;
        if ((rise & fall) != 4'h0) begin
            errors++;
            $display("FAIL rise_and_fall_overlap: rise=%h fall=%h required overlap 0", rise, fall);
        end
    end

    typedef struct {
        int unsigned n;
        logic        rst;
        logic [3:0]  raw;
        logic [3:0]  lvl;
        logic [3:0]  rise;
        logic [3:0]  fall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int unsigned n, input logic r, input logic [3:0] rw,
                       input logic [3:0] l, input logic [3:0] rs, input logic [3:0] f);
        vec_t v;
        v.n = n; v.rst = r; v.raw = rw; v.lvl = l; v.rise = rs; v.fall = f;
        tbl.push_back(v);
    endtask

    // Drive inputs mid-cycle, let them be captured on the next rising edge,
    // then sample outputs just after that edge.
    task automatic step(input logic r, input logic [3:0] rw);
        @(negedge clk);
        rst = r;
        raw = rw;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] l,
                         input logic [3:0] rs, input logic [3:0] f);
        checks += 3;
        if (level !== l) begin
            errors++;
            $display("FAIL %s level: got %h required %h (t=%0t)", name, level, l, $time);
        end
        if (rise !== rs) begin
            errors++;
            $display("FAIL %s rise: got %h required %h (t=%0t)", name, rise, rs, $time);
        end
        if (fall !== f) begin
            errors++;
            $display("FAIL %s fall: got %h required %h (t=%0t)", name, fall, f, $time);
        end
    endtask

    initial begin
        // {cycles, rst, raw, expected level, rise, fall}
        // Reset with all buttons held; held buttons become a press on release.
        add(3, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(5, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
        add(3, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
        // Release everything together.
        add(5, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
        add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
        add(3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Clean press and release of bit 0.
        add(5, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'h1, 4'h1, 4'h1, 4'h0);
        add(4, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
        add(5, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Bit 2 high for 3 cycles: one short of acceptance.
        add(3, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(8, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Bit 3 high for exactly 4 cycles: just enough to be accepted.
        add(4, 1'b0, 4'h8, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'h0, 4'h8, 4'h8, 4'h0);
        add(3, 1'b0, 4'h0, 4'h8, 4'h0, 4'h0);
        add(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h8);
        add(2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

        foreach (tbl[idx]) begin
            for (int c = 0; c < int'(tbl[idx].n); c++) begin
                step(tbl[idx].rst, tbl[idx].raw);
                check($sformatf("vec%0d.%0d", idx, c), tbl[idx].lvl, tbl[idx].rise, tbl[idx].fall);
            end
        end

        // Bounce on bit 1: 1,1,1,0,1,1,1,0 never reaches 4 stable cycles.
        begin
            logic [3:0] pat [8];
            pat = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
            for (int c = 0; c < 8; c++) begin
                step(1'b0, pat[c]);
                check($sformatf("bounce_pat%0d", c), 4'h0, 4'h0, 4'h0);
            end
            // Final 0->1 capture is the first of these edges; rise 5 edges later.
            for (int c = 0; c < 5; c++) begin
                step(1'b0, 4'h2);
                check($sformatf("bounce_settle%0d", c), 4'h0, 4'h0, 4'h0);
            end
            step(1'b0, 4'h2);
            check("bounce_rise", 4'h2, 4'h2, 4'h0);
            step(1'b0, 4'h2);
            check("bounce_after", 4'h2, 4'h0, 4'h0);
            for (int c = 0; c < 5; c++) begin
                step(1'b0, 4'h0);
                check($sformatf("bounce_rel%0d", c), 4'h2, 4'h0, 4'h0);
            end
            step(1'b0, 4'h0);
            check("bounce_fall", 4'h0, 4'h0, 4'h2);
            for (int c = 0; c < 3; c++) begin
                step(1'b0, 4'h0);
                check("bounce_idle", 4'h0, 4'h0, 4'h0);
            end
        end

        // Bits 0 and 2 rise together; bit 0 drops after 2 cycles.
        step(1'b0, 4'h5);
        check("simul_k0", 4'h0, 4'h0, 4'h0);
        step(1'b0, 4'h5);
        check("simul_k1", 4'h0, 4'h0, 4'h0);
        for (int c = 2; c < 5; c++) begin
            step(1'b0, 4'h4);
            check($sformatf("simul_k%0d", c), 4'h0, 4'h0, 4'h0);
        end
        step(1'b0, 4'h4);
        check("simul_rise", 4'h4, 4'h4, 4'h0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'h4);
            check("simul_hold", 4'h4, 4'h0, 4'h0);
        end

        // Bit 3 pending (and bit 2 pending fall) when reset hits: both discarded
        // with no pulse; held bit 3 is then re-accepted after release.
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'h8);
            check($sformatf("rstmid_pend%0d", c), 4'h4, 4'h0, 4'h0);
        end
        step(1'b1, 4'h8);
        check("rstmid_reset", 4'h0, 4'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'h8);
            check($sformatf("rstmid_wait%0d", c), 4'h0, 4'h0, 4'h0);
        end
        step(1'b0, 4'h8);
        check("rstmid_rise", 4'h8, 4'h8, 4'h0);
        step(1'b0, 4'h8);
        check("rstmid_after", 4'h8, 4'h0, 4'h0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
